// File: rtl/inst_rom_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_rom_loader_pkg
// Shared constants and types for the instruction ROM loader.
//   InstBus / InstAddrBus   : widths of the instruction word and fetch address
//   ChipEnable/ChipDisable  : polarity of the fetch chip enable
//   RstEnable               : polarity of the core reset output
//   ZeroWord                : value returned for masked fetches (reads as nop)
//   InstMemNumLog2Def       : default log2 of instruction memory depth (words)
// -----------------------------------------------------------------------------
package inst_rom_loader_pkg;

  localparam int          InstBus           = 32;
  localparam int          InstAddrBus       = 32;
  localparam logic        ChipEnable        = 1'b1;
  localparam logic        ChipDisable       = 1'b0;
  localparam logic        RstEnable         = 1'b1;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam int          InstMemNumLog2Def = 10;

  // Loader state: LOAD accepts bytes, RUN and ERR are terminal until reset.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } ld_state_e;

endpackage

// File: rtl/inst_mem_array.sv
// -----------------------------------------------------------------------------
// inst_mem_array
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the loader masks unwritten words instead.
// Ports:
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write word address
//   wdata_i : write data
//   raddr_i : read word address (combinational read)
//   rdata_o : read data
// -----------------------------------------------------------------------------
module inst_mem_array #(
  parameter int AddrW = 10,
  parameter int DataW = 32
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] r_mem [2**AddrW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  // The core samples the instruction on the same edge as its PC, so the
  // read path must be zero latency.
  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// -----------------------------------------------------------------------------
// inst_rom_loader
// Streams a byte-wise program image into instruction memory, then releases
// the core from reset and serves instruction fetches.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   ld_valid_i   : loader byte valid
//   ld_data_i    : loader byte
//   ld_last_i    : final byte of image (qualified by ld_valid_i)
//   ld_ready_o   : byte accepted when ld_valid_i & ld_ready_o
//   rom_ce_i     : fetch chip enable
//   rom_addr_i   : fetch byte address
//   rom_data_o   : fetched word (combinational; zero when masked)
//   cpu_rst_o    : core reset, registered, high until one edge after RUN
//   load_done_o  : image loaded, core running
//   err_o        : sticky load error
// -----------------------------------------------------------------------------
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int InstMemNumLog2 = InstMemNumLog2Def
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_valid_i,
  input  logic [7:0]             ld_data_i,
  input  logic                   ld_last_i,
  output logic                   ld_ready_o,
  input  logic                   rom_ce_i,
  input  logic [InstAddrBus-1:0] rom_addr_i,
  output logic [InstBus-1:0]     rom_data_o,
  output logic                   cpu_rst_o,
  output logic                   load_done_o,
  output logic                   err_o
);

  // wptr needs one extra bit to represent "memory full" (== depth).
  localparam int WptrW    = InstMemNumLog2 + 1;
  localparam int MemDepth = 1 << InstMemNumLog2;

  ld_state_e          r_state;
  ld_state_e          w_state_next;
  logic [1:0]         r_cnt;
  logic [1:0]         w_cnt_next;
  logic [23:0]        r_asm;
  logic [23:0]        w_asm_next;
  logic [WptrW-1:0]   r_wptr;
  logic [WptrW-1:0]   w_wptr_next;
  logic               r_cpu_rst;

  logic               w_accept;
  logic               w_full;
  logic               w_we;
  logic [31:0]        w_wdata;
  logic [InstMemNumLog2-1:0] w_waddr;
  logic [InstBus-1:0] w_rdata;
  logic [29:0]        w_fetch_idx;
  logic               w_in_range;
  logic               w_unused_addr_bits;

  assign w_accept = ld_valid_i && (r_state == ST_LOAD);
  assign w_full   = (r_wptr == WptrW'(MemDepth));
  assign w_waddr  = r_wptr[InstMemNumLog2-1:0];
  // Big-endian: earlier bytes sit higher in the assembly register.
  assign w_wdata  = {r_asm, ld_data_i};

  // Next-state / datapath control.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_asm_next   = r_asm;
    w_wptr_next  = r_wptr;
    w_we         = 1'b0;
    if (w_accept) begin
      if (w_full) begin
        // No room for another word: reject and write nothing.
        w_state_next = ST_ERR;
      end else if (r_cnt == 2'd3) begin
        w_we        = 1'b1;
        w_wptr_next = r_wptr + WptrW'(1);
        w_cnt_next  = 2'd0;
        w_asm_next  = 24'h0;
        if (ld_last_i) begin
          w_state_next = ST_RUN;
        end
      end else begin
        w_cnt_next = r_cnt + 2'd1;
        w_asm_next = w_wdata[23:0];
        // Image ended mid-word: the partial word is dropped.
        if (ld_last_i) begin
          w_state_next = ST_ERR;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_LOAD;
      r_cnt     <= 2'd0;
      r_asm     <= 24'h0;
      r_wptr    <= '0;
      r_cpu_rst <= RstEnable;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_asm     <= w_asm_next;
      r_wptr    <= w_wptr_next;
      // Uses the current state, so the core leaves reset one edge after RUN.
      r_cpu_rst <= (r_state != ST_RUN) ? RstEnable : ~RstEnable;
    end
  end

  inst_mem_array #(
    .AddrW (InstMemNumLog2),
    .DataW (InstBus)
  ) u_mem (
    .clk     (clk),
    .we_i    (w_we),
    .waddr_i (w_waddr),
    .wdata_i (w_wdata),
    .raddr_i (rom_addr_i[InstMemNumLog2+1:2]),
    .rdata_o (w_rdata)
  );

  // Words at or beyond wptr were never loaded (stale after reset): read as nop.
  assign w_fetch_idx        = rom_addr_i[31:2];
  assign w_in_range         = (w_fetch_idx < 30'(r_wptr));
  assign w_unused_addr_bits = ^rom_addr_i[1:0];

  assign rom_data_o  = ((rom_ce_i == ChipEnable) && (r_state == ST_RUN) && w_in_range)
                       ? w_rdata : ZeroWord;
  assign ld_ready_o  = (r_state == ST_LOAD);
  assign load_done_o = (r_state == ST_RUN);
  assign err_o       = (r_state == ST_ERR);
  assign cpu_rst_o   = r_cpu_rst;

endmodule

// File: tb/tb_inst_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_loader
// Directed bench with a scoreboard: stimulus queues expected values, a monitor
// on the falling edge pops and compares them against the DUT outputs.
// Two instances share all inputs: default depth and a 4-word memory.
// -----------------------------------------------------------------------------
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_last = 1'b0;
  logic        rom_ce = 1'b0;
  logic [31:0] rom_addr = 32'h0;

  logic        ready_b, cpu_rst_b, done_b, err_b;
  logic [31:0] data_b;
  logic        ready_s, cpu_rst_s, done_s, err_s;
  logic [31:0] data_s;

  always #5 clk = ~clk;

  inst_rom_loader dut (
    .clk (clk), .rst (rst),
    .ld_valid_i (ld_valid), .ld_data_i (ld_data), .ld_last_i (ld_last),
    .ld_ready_o (ready_b),
    .rom_ce_i (rom_ce), .rom_addr_i (rom_addr), .rom_data_o (data_b),
    .cpu_rst_o (cpu_rst_b), .load_done_o (done_b), .err_o (err_b)
  );

  inst_rom_loader #(.InstMemNumLog2(2)) dut_s (
    .clk (clk), .rst (rst),
    .ld_valid_i (ld_valid), .ld_data_i (ld_data), .ld_last_i (ld_last),
    .ld_ready_o (ready_s),
    .rom_ce_i (rom_ce), .rom_addr_i (rom_addr), .rom_data_o (data_s),
    .cpu_rst_o (cpu_rst_s), .load_done_o (done_s), .err_o (err_s)
  );

  localparam int S_DATA = 0, S_READY = 1, S_CPURST = 2, S_DONE = 3, S_ERR = 4,
                 S_DATA_S = 5, S_ERR_S = 6, S_DONE_S = 7, S_READY_S = 8;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  logic probe = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: compares every queued expectation when the bench raises probe.
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    if (probe) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: probe raised with empty queue");
      end
      while (q.size() > 0) begin
        c = q.pop_front();
        case (c.sel)
          S_DATA:    act = data_b;
          S_READY:   act = {31'h0, ready_b};
          S_CPURST:  act = {31'h0, cpu_rst_b};
          S_DONE:    act = {31'h0, done_b};
          S_ERR:     act = {31'h0, err_b};
          S_DATA_S:  act = data_s;
          S_ERR_S:   act = {31'h0, err_s};
          S_DONE_S:  act = {31'h0, done_s};
          S_READY_S: act = {31'h0, ready_s};
          default:   act = 32'hxxxx_xxxx;
        endcase
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end else begin
          $display("ok   %s: %h", c.name, act);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // All tasks start and end 1 ns after a rising edge.
  task automatic push(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    q.push_back(c);
  endtask

  task automatic sample();
    probe = 1'b1;
    @(negedge clk);
    #1 probe = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string name, input int sel, input logic ce,
                       input logic [31:0] addr, input logic [31:0] exp);
    rom_ce   = ce;
    rom_addr = addr;
    push(name, sel, exp);
    sample();
  endtask

  task automatic send(input logic [7:0] d, input logic last, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [7:0] img [8];

  initial begin
    img[0] = 8'h3C; img[1] = 8'h01; img[2] = 8'h12; img[3] = 8'h34;
    img[4] = 8'h34; img[5] = 8'h21; img[6] = 8'h56; img[7] = 8'h78;
    #1;
    do_reset();

    // Reset state.
    push("rst_ready", S_READY, 32'h1);
    push("rst_done", S_DONE, 32'h0);
    push("rst_err", S_ERR, 32'h0);
    push("rst_cpu_rst", S_CPURST, 32'h1);
    sample();
    fetch("rst_fetch0", S_DATA, 1'b1, 32'h0, 32'h0);

    // Basic 2-word image.
    for (int i = 0; i < 8; i++) send(img[i], (i == 7), 0);
    push("run_cpu_rst_still_hi", S_CPURST, 32'h1);
    push("run_done", S_DONE, 32'h1);
    sample();
    push("run_cpu_rst_low", S_CPURST, 32'h0);
    push("run_ready_low", S_READY, 32'h0);
    sample();
    fetch("fetch_0x0", S_DATA, 1'b1, 32'h0, 32'h3C01_1234);
    fetch("fetch_0x4", S_DATA, 1'b1, 32'h4, 32'h3421_5678);
    fetch("fetch_0x6_lowbits", S_DATA, 1'b1, 32'h6, 32'h3421_5678);
    fetch("fetch_0x8", S_DATA, 1'b1, 32'h8, 32'h0);
    fetch("fetch_ce0", S_DATA, 1'b0, 32'h0, 32'h0);

    // Bytes offered in RUN are ignored.
    ld_valid = 1'b1;
    ld_data  = 8'hFF;
    push("run_ignore_ready", S_READY, 32'h0);
    sample();
    ld_data = 8'hEE;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    fetch("run_keep_0x0", S_DATA, 1'b1, 32'h0, 32'h3C01_1234);
    fetch("run_keep_0x4", S_DATA, 1'b1, 32'h4, 32'h3421_5678);
    fetch("run_keep_0x8", S_DATA, 1'b1, 32'h8, 32'h0);

    // Same image with random idle gaps.
    do_reset();
    fetch("rst_masks_stale", S_DATA, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) send(img[i], (i == 7), int'($urandom_range(0, 3)));
    push("gap_done", S_DONE, 32'h1);
    sample();
    fetch("gap_fetch_0x0", S_DATA, 1'b1, 32'h0, 32'h3C01_1234);
    fetch("gap_fetch_0x4", S_DATA, 1'b1, 32'h4, 32'h3421_5678);
    fetch("gap_fetch_0x8", S_DATA, 1'b1, 32'h8, 32'h0);

    // Reset mid-word, then a fresh single-word image.
    do_reset();
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b0, 0);
    do_reset();
    send(8'hAA, 1'b0, 0);
    send(8'hBB, 1'b0, 0);
    send(8'hCC, 1'b0, 0);
    send(8'hDD, 1'b1, 0);
    push("midrst_done", S_DONE, 32'h1);
    sample();
    fetch("midrst_fetch_0x0", S_DATA, 1'b1, 32'h0, 32'hAABB_CCDD);
    fetch("midrst_fetch_0x4", S_DATA, 1'b1, 32'h4, 32'h0);

    // Partial final word -> ERR.
    do_reset();
    for (int i = 0; i < 6; i++) send(img[i], (i == 5), 0);
    push("partial_err", S_ERR, 32'h1);
    push("partial_cpu_rst", S_CPURST, 32'h1);
    push("partial_done", S_DONE, 32'h0);
    push("partial_ready", S_READY, 32'h0);
    sample();
    fetch("partial_fetch_0x0", S_DATA, 1'b1, 32'h0, 32'h0);
    send(8'h99, 1'b0, 0);
    send(8'h98, 1'b1, 0);
    push("partial_err_sticky", S_ERR, 32'h1);
    push("partial_cpu_rst_sticky", S_CPURST, 32'h1);
    sample();

    // Last flag on the very first byte.
    do_reset();
    send(8'h3C, 1'b1, 0);
    push("first_last_err", S_ERR, 32'h1);
    push("first_last_done", S_DONE, 32'h0);
    sample();

    // 4-word memory: overflow byte -> ERR.
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0, 0);
    push("small_full_ready", S_READY_S, 32'h1);
    push("small_full_err_pending", S_ERR_S, 32'h0);
    sample();
    send(8'h55, 1'b0, 0);
    push("small_overflow_err", S_ERR_S, 32'h1);
    push("small_overflow_done", S_DONE_S, 32'h0);
    sample();

    // 4-word memory: exact fill with last -> RUN.
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), (i == 15), 0);
    push("small_done", S_DONE_S, 32'h1);
    push("small_err", S_ERR_S, 32'h0);
    sample();
    fetch("small_fetch_0x0", S_DATA_S, 1'b1, 32'h0, 32'h1011_1213);
    fetch("small_fetch_0xC", S_DATA_S, 1'b1, 32'hC, 32'h1C1D_1E1F);
    fetch("small_fetch_0x10", S_DATA_S, 1'b1, 32'h10, 32'h0);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
